// File: rtl/c2_seq_multiplier.sv
// rtl/c2_seq_multiplier.sv - sequential shift-and-add unsigned multiplier around a C2-cell ripple-carry adder
// One adder pass per cycle; the product lands in a held register with a one-cycle done pulse.

module c2_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module c2_ripple_adder #(
  parameter int W = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] carry;

  assign carry[0] = 1'b0;
  assign co       = carry[W];

  for (genvar i = 0; i < W; i++) begin : g_cell
    c2_cell u_cell (
      .x  (x[i]),
      .y  (y[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end
endmodule

module c2_seq_multiplier #(
  parameter int SIZE = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product
);
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SIZE-1:0]   a_q;
  logic [SIZE-1:0]   p_hi;
  logic [SIZE-1:0]   q;
  logic [CW-1:0]     cnt;
  logic [2*SIZE-1:0] product_q;

  logic [SIZE-1:0]   addend;
  logic [SIZE-1:0]   sum;
  logic              carry;
  logic [2*SIZE-1:0] next_pq;
  logic              last_iter;

  assign addend = q[0] ? a_q : '0;

  c2_ripple_adder #(.W(SIZE)) u_adder (
    .x  (p_hi),
    .y  (addend),
    .s  (sum),
    .co (carry)
  );

  // {carry,sum,q} shifted right by one; q[0] has been consumed as the multiplier bit
  assign next_pq   = {carry, sum, q[SIZE-1:1]};
  assign last_iter = (cnt == CW'(SIZE - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      p_hi      <= '0;
      q         <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            q    <= b;
            p_hi <= '0;
            cnt  <= '0;
          end
        end
        ADD: begin
          p_hi <= next_pq[2*SIZE-1:SIZE];
          q    <= next_pq[SIZE-1:0];
          cnt  <= cnt + CW'(1);
          if (last_iter) product_q <= next_pq;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q == ADD);
  assign done    = (state_q == DONE);
  assign product = product_q;
endmodule

// File: tb/tb_c2_seq_multiplier.sv
// tb/tb_c2_seq_multiplier.sv - self-checking bench for c2_seq_multiplier
module tb_c2_seq_multiplier;
  localparam int SIZE = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [SIZE-1:0]   a = '0;
  logic [SIZE-1:0]   b = '0;
  logic              busy;
  logic              done;
  logic [2*SIZE-1:0] product;

  int vectors = 0;
  int errors  = 0;

  c2_seq_multiplier #(.SIZE(SIZE)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: an accepted request is busy for SIZE cycles, then done for one with a*b.
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_prod = '0;
  logic [31:0] m_pending = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (!rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_prod = '0;
      m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_prod = m_pending;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      m_pending = 32'(a) * 32'(b);
      m_busy    = 1'b1;
      m_left    = SIZE;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("product", 32'(product), m_prod);
    end
  end

  task automatic run_mul(input string name, input int av, input int bv, input int exp);
    int lat;
    a = SIZE'(av);
    b = SIZE'(bv);
    start = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        a = SIZE'($urandom);
        b = SIZE'($urandom);
      end
      if (done) break;
    end
    chk({name, "_latency"}, 32'(lat), 32'(SIZE + 1));
    chk({name, "_product"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int extra;
    int prev;
    int ndone;

    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_product", 32'(product), 32'd0);

    run_mul("max", 31, 31, 961);
    repeat (10) @(negedge clk);
    chk("max_held", 32'(product), 32'd961);

    run_mul("identity", 13, 1, 13);
    @(negedge clk);
    run_mul("zero", 0, 17, 0);
    @(negedge clk);
    run_mul("carry", 16, 30, 480);
    @(negedge clk);

    // start pulse during ADD must be ignored
    a = 5'd3; b = 5'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 5'd7; b = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    while (!done && extra < 20) begin
      @(negedge clk);
      extra++;
    end
    chk("ignored_start_product", 32'(product), 32'd15);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignored_start_no_second_done", 32'(ndone), 32'd0);

    // reset during iteration 3
    a = 5'd9; b = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_product", 32'(product), 32'd0);
    run_mul("after_reset", 2, 11, 22);
    @(negedge clk);

    // start held high: one product every SIZE+2 cycles
    a = 5'd6; b = 5'd7; start = 1'b1;
    prev = -1;
    ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("b2b_product", 32'(product), 32'd42);
        if (prev >= 0) chk("b2b_spacing", 32'(i - prev), 32'd7);
        prev = i;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(ndone), 32'd4);
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/c2_seq_multiplier.md
Name: c2_seq_multiplier

Overview:
- Sequential shift-and-add unsigned multiplier; the control and register stage around the team's C2-cell ripple-carry adder.
- Each iteration drives the adder with the running upper partial product and the multiplicand, captures sum and carry, then shifts.
- Produces a 2*SIZE-bit product SIZE cycles after a start is accepted.
- Downstream datapath blocks consume it through a done pulse plus a held result register.

Parameters:
- SIZE, 5: operand width in bits. Product width is 2*SIZE; iteration count is SIZE.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low. rst=0 at a rising edge resets the block.
- start  input  1  request a multiply. Sampled only in IDLE.
- a  input  SIZE  multiplicand, unsigned. Sampled on the edge that accepts start.
- b  input  SIZE  multiplier, unsigned. Sampled on the edge that accepts start.
- busy  output  1  high in ADD state.
- done  output  1  high for exactly one cycle, in DONE state.
- product  output  2*SIZE  result register. Valid while done=1; held until the next accepted start.

Behaviour:
- Reset (rst=0 at an edge, in any state, including mid-operation):
  - state=IDLE; all internal registers cleared (A, P_hi, Q, c, cnt).
  - product=0, busy=0, done=0.
  - An in-flight operation is discarded; no done is produced for it.
- Registers:
  - A [SIZE]: multiplicand.
  - P_hi [SIZE]: upper partial product.
  - Q [SIZE]: multiplier / lower product half.
  - cnt [ceil(log2(SIZE+1))]: iteration counter.
  - product [2*SIZE].
- FSM states: IDLE, ADD, DONE. busy=(state==ADD); done=(state==DONE); both decoded directly from the state register.
- IDLE:
  - start=1 at an edge: A<=a, Q<=b, P_hi<=0, cnt<=0, state<=ADD.
  - start=0: remain in IDLE; product holds.
- ADD, one iteration per cycle:
  - Adder operands are P_hi and (Q[0] ? A : 0). Result {c,S} is SIZE+1 bits; c is the adder carry out, which is never dropped.
  - At the edge: {P_hi,Q} <= {c,S,Q} >> 1, i.e. P_hi<={c,S[SIZE-1:1]} and Q<={S[0],Q[SIZE-1:1]}. cnt<=cnt+1.
  - When cnt==SIZE-1 at the edge (last iteration): product <= {new P_hi, new Q}, state<=DONE.
- DONE: lasts one cycle, then state<=IDLE unconditionally.
- Ignored requests:
  - start is ignored in ADD and DONE; no queuing.
  - A start held high through DONE is accepted on the first IDLE edge.
- Timing: if start is accepted at edge E0, iterations occur at edges E0+1 .. E0+SIZE.
  - busy=1 during cycles E0..E0+SIZE-1.
  - done=1 and product valid in the cycle after edge E0+SIZE.
  - Earliest back-to-back accept is edge E0+SIZE+2, so throughput is 1 product per SIZE+2 cycles.
- Arithmetic: the result is exact for all operand pairs, since the maximum (2^SIZE-1)^2 fits in 2*SIZE bits. No overflow or truncation.
- Inputs a and b may change freely after the accept edge without affecting the result.

Test Plan:
- Reset then idle (SIZE=5): rst=0 for 2 edges, then start=0 for 10 cycles -> product=0, busy=0, done=0 throughout.
- Maximum operands: a=31, b=31, start 1 cycle -> busy=1 for 5 cycles, then done=1 for one cycle with product=961 (0x3C1). Product still 961 ten cycles later.
- Carry path and zero/identity cases:
  - a=13, b=1 -> 13.
  - a=0, b=17 -> 0.
  - a=16, b=30 -> 480. Confirms c is captured and shifted in.
- Start while busy: accept a=3, b=5; pulse start with a=7, b=7 during ADD -> a single done with product=15; no second done follows.
- Reset mid-operation: accept a=9, b=9; rst=0 at iteration 3 -> next cycle busy=0, done=0, product=0. A following a=2, b=11 gives 22 with normal timing.
- Back-to-back: start held high continuously with a=6, b=7 -> done every 7 cycles (SIZE+2), product=42 each time.
